// File: rtl/divider_8b_4b_pkg.sv
// rtl/divider_8b_4b_pkg.sv - shared widths, constants and state type for the 8/4 divider
//
// Package divider_pkg
//   DVD_W, DVS_W, STEP_W : dividend, divisor and step-counter widths
//   DZ_Q, DZ_R           : quotient/remainder reported for a zero divisor
//   STEP_LAST            : counter value of the final quotient-bit iteration
//   state_t              : controller states IDLE, CALC, DONE
package divider_pkg;

   localparam int DVD_W  = 8;
   localparam int DVS_W  = 4;
   localparam int STEP_W = 3;

   localparam logic [DVD_W-1:0]  DZ_Q      = 8'hFF;
   localparam logic [DVS_W-1:0]  DZ_R      = 4'hF;
   localparam logic [STEP_W-1:0] STEP_LAST = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/divider_8b_4b_if.sv
// rtl/divider_8b_4b_if.sv - operand/result handshake bundle for the 8/4 divider
//
// Signals
//   in_valid / in_ready   : operand handshake (x dividend, y divisor)
//   out_valid / out_ready : result handshake (q quotient, r remainder, dz divide-by-zero)
// Modports
//   master : producer of operands and consumer of results
//   slave  : the divider
interface divider_8b_4b_if;
   import divider_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [DVD_W-1:0] x;
   logic [DVS_W-1:0] y;
   logic             out_valid;
   logic             out_ready;
   logic [DVD_W-1:0] q;
   logic [DVS_W-1:0] r;
   logic             dz;

   modport master (
      output in_valid, x, y, out_ready,
      input  in_ready, out_valid, q, r, dz
   );

   modport slave (
      input  in_valid, x, y, out_ready,
      output in_ready, out_valid, q, r, dz
   );

endinterface

// File: rtl/divider_8b_4b_div_step.sv
// rtl/divider_8b_4b_div_step.sv - one restoring-division step (trial subtract / restore)
//
// Ports
//   pr_i   in  4  current partial remainder (always < y)
//   bit_i  in  1  next dividend bit, MSB first
//   y_i    in  4  divisor
//   pr_o   out 4  partial remainder after this step
//   q_o    out 1  quotient bit produced by this step
module div_step
   import divider_pkg::*;
(
   input  logic [DVS_W-1:0] pr_i,
   input  logic             bit_i,
   input  logic [DVS_W-1:0] y_i,
   output logic [DVS_W-1:0] pr_o,
   output logic             q_o
);

   logic [DVS_W:0]   t;
   logic [DVS_W-1:0] diff;

   assign t = {pr_i, bit_i};

   // When t >= y we also have t < 2*y, so t - y < 16 and the low four bits
   // of the subtraction are exact; no fifth difference bit is needed.
   assign diff = t[DVS_W-1:0] - y_i;
   assign q_o  = (t >= {1'b0, y_i});
   assign pr_o = q_o ? diff : t[DVS_W-1:0];

endmodule

// File: rtl/divider_8b_4b.sv
// rtl/divider_8b_4b.sv - sequential radix-2 restoring divider, 8-bit dividend / 4-bit divisor
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave of divider_8b_4b_if: in_valid/in_ready/x/y operand side,
//          out_valid/out_ready/q/r/dz result side
// One quotient bit per cycle in CALC; quotient bits replace dividend bits in
// the shift register.  Results are copied into holding registers on entry to
// DONE so q/r/dz keep their last value while the next operation runs.
module divider_8b_4b
   import divider_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   divider_8b_4b_if.slave  bus
);

   state_t            state_q, state_d;
   logic [STEP_W-1:0] cnt_q, cnt_d;
   logic [DVD_W-1:0]  shift_q, shift_d;
   logic [DVS_W-1:0]  pr_q, pr_d;
   logic [DVS_W-1:0]  dvs_q, dvs_d;
   logic              dzp_q, dzp_d;
   logic [DVD_W-1:0]  q_q, q_d;
   logic [DVS_W-1:0]  r_q, r_d;
   logic              dz_q, dz_d;

   logic [DVS_W-1:0]  pr_nxt;
   logic              qbit;

   div_step u_step (
      .pr_i  (pr_q),
      .bit_i (shift_q[DVD_W-1]),
      .y_i   (dvs_q),
      .pr_o  (pr_nxt),
      .q_o   (qbit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         pr_q    <= '0;
         dvs_q   <= '0;
         dzp_q   <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         pr_q    <= pr_d;
         dvs_q   <= dvs_d;
         dzp_q   <= dzp_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dz_q    <= dz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      pr_d    = pr_q;
      dvs_d   = dvs_q;
      dzp_d   = dzp_q;
      q_d     = q_q;
      r_d     = r_q;
      dz_d    = dz_q;

      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               shift_d = bus.x;
               dvs_d   = bus.y;
               pr_d    = '0;
               cnt_d   = '0;
               dzp_d   = (bus.y == '0);
               state_d = CALC;
            end
         end

         CALC: begin
            if (dzp_q) begin
               // Zero divisor: a single pass through CALC, then the fixed
               // saturated result, so out_valid appears one edge after accept.
               q_d     = DZ_Q;
               r_d     = DZ_R;
               dz_d    = 1'b1;
               state_d = DONE;
            end else begin
               shift_d = {shift_q[DVD_W-2:0], qbit};
               pr_d    = pr_nxt;
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == STEP_LAST) begin
                  q_d     = {shift_q[DVD_W-2:0], qbit};
                  r_d     = pr_nxt;
                  dz_d    = 1'b0;
                  state_d = DONE;
               end
            end
         end

         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.q         = q_q;
   assign bus.r         = r_q;
   assign bus.dz        = dz_q;

endmodule

// File: tb/tb_divider_8b_4b.sv
// tb/tb_divider_8b_4b.sv - self-checking bench for divider_8b_4b
module tb_divider_8b_4b;

   typedef struct packed {
      logic [7:0] q;
      logic [3:0] r;
      logic       dz;
   } res_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   n_ret;
   res_t exp_q[$];

   divider_8b_4b_if dif ();

   divider_8b_4b dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic res_t model(input logic [7:0] xv, input logic [3:0] yv);
      res_t m;
      int   xi;
      int   yi;
      xi = int'(xv);
      yi = int'(yv);
      if (yi == 0) begin
         m.q  = 8'hFF;
         m.r  = 4'hF;
         m.dz = 1'b1;
      end else begin
         m.q  = 8'(xi / yi);
         m.r  = 4'(xi % yi);
         m.dz = 1'b0;
      end
      return m;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Runs at the falling edge: inputs and outputs are both stable here.
   task automatic monitor();
      res_t e;
      if (!rst_n) begin
         exp_q.delete();
         return;
      end
      chk("ready_valid_exclusive", int'(dif.in_ready & dif.out_valid), 0);
      if (dif.out_valid) begin
         chk("result_pending", int'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q[0];
            chk("model_q", int'(dif.q), int'(e.q));
            chk("model_r", int'(dif.r), int'(e.r));
            chk("model_dz", int'(dif.dz), int'(e.dz));
            if (dif.out_ready) begin
               void'(exp_q.pop_front());
               n_ret++;
            end
         end
      end
      if (dif.in_valid && dif.in_ready) begin
         exp_q.push_back(model(dif.x, dif.y));
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] xv, input logic [3:0] yv);
      int n;
      n = 0;
      while (!dif.in_ready && n < 50) begin
         tick();
         n++;
      end
      chk("send_ready", int'(dif.in_ready), 1);
      dif.in_valid = 1'b1;
      dif.x        = xv;
      dif.y        = yv;
      tick();
      dif.in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!dif.out_valid && lat < 40) begin
         tick();
         lat++;
      end
      chk("result_timeout", int'(dif.out_valid), 1);
   endtask

   task automatic take();
      dif.out_ready = 1'b1;
      tick();
      dif.out_ready = 1'b0;
      chk("idle_in_ready", int'(dif.in_ready), 1);
      chk("idle_out_valid", int'(dif.out_valid), 0);
   endtask

   task automatic run(input logic [7:0] xv, input logic [3:0] yv,
                      input int eq, input int er, input int edz, input int elat);
      int lat;
      send(xv, yv);
      wait_valid(lat);
      chk("latency", lat, elat);
      chk("lit_q", int'(dif.q), eq);
      chk("lit_r", int'(dif.r), er);
      chk("lit_dz", int'(dif.dz), edz);
      take();
   endtask

   initial begin
      res_t pin;
      int   idx;
      int   budget;
      int   a;
      int   b;
      logic rdy;
      int   n;

      checks        = 0;
      errors        = 0;
      n_ret         = 0;
      rst_n         = 1'b0;
      dif.in_valid  = 1'b0;
      dif.out_ready = 1'b0;
      dif.x         = '0;
      dif.y         = '0;

      pin = model(8'd200, 4'd7);
      chk("model_pin_q", int'(pin.q), 28);
      chk("model_pin_r", int'(pin.r), 4);
      pin = model(8'd100, 4'd0);
      chk("model_pin_dz_q", int'(pin.q), 255);

      tick();
      tick();
      chk("rst_in_ready", int'(dif.in_ready), 1);
      chk("rst_out_valid", int'(dif.out_valid), 0);
      chk("rst_q", int'(dif.q), 0);
      chk("rst_r", int'(dif.r), 0);
      chk("rst_dz", int'(dif.dz), 0);
      rst_n = 1'b1;
      tick();

      run(8'd200, 4'd7, 28, 4, 0, 8);
      run(8'd255, 4'd1, 255, 0, 0, 8);
      run(8'd5, 4'd9, 0, 5, 0, 8);
      run(8'd15, 4'd15, 1, 0, 0, 8);
      run(8'd100, 4'd0, 255, 15, 1, 1);

      // Backpressure: DONE holds while out_ready is low; operand pulses ignored.
      send(8'd77, 4'd3);
      wait_valid(n);
      for (int i = 0; i < 5; i++) begin
         dif.in_valid = (i % 2 == 0);
         dif.x        = 8'd9;
         dif.y        = 4'd1;
         tick();
         chk("hold_out_valid", int'(dif.out_valid), 1);
         chk("hold_q", int'(dif.q), 25);
         chk("hold_r", int'(dif.r), 2);
         chk("hold_in_ready", int'(dif.in_ready), 0);
      end
      dif.in_valid = 1'b0;
      take();

      // Reset during the fourth CALC iteration aborts the operation.
      send(8'd200, 4'd7);
      tick();
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", int'(dif.in_ready), 1);
      chk("abort_out_valid", int'(dif.out_valid), 0);
      chk("abort_q", int'(dif.q), 0);
      chk("abort_r", int'(dif.r), 0);
      chk("abort_dz", int'(dif.dz), 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_abort_out_valid", int'(dif.out_valid), 0);
      run(8'd49, 4'd7, 7, 0, 0, 8);

      // Round trip a*b / b for every 4-bit pair, random result backpressure.
      n_ret  = 0;
      idx    = 0;
      budget = 0;
      while (idx < 240 && budget < 20000) begin
         if (!dif.in_valid) begin
            a            = idx / 15;
            b            = idx % 15 + 1;
            dif.in_valid = 1'b1;
            dif.x        = 8'(a * b);
            dif.y        = 4'(b);
         end
         dif.out_ready = 1'($urandom_range(0, 1));
         rdy = dif.in_ready;
         tick();
         budget++;
         if (dif.in_valid && rdy) begin
            idx++;
            dif.in_valid = 1'b0;
         end
      end
      chk("sweep_accepts", idx, 240);
      dif.in_valid  = 1'b0;
      dif.out_ready = 1'b1;
      n = 0;
      while ((exp_q.size() > 0 || dif.out_valid) && n < 100) begin
         tick();
         n++;
      end
      chk("sweep_drained", exp_q.size(), 0);
      chk("sweep_results", n_ret, 240);
      dif.out_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
